// File: rtl/selector_addr_seq.sv
// Address sweep generator feeding the one-hot selector; valid/ready per address.
// Define SEL_SEQ_LFSR_EN to add cfg_rand (8-bit LFSR pseudo-random ordering).
module selector_addr_seq #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] cfg_first,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_dwell,
  input  logic              cfg_loop,
`ifdef SEL_SEQ_LFSR_EN
  input  logic              cfg_rand,
`endif
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_DWELL
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [CNT_W-1:0]  ONE_C = 1;

  state_t            r_state, w_state_n;
  logic [ADDR_W-1:0] r_first, r_last, r_stride;
  logic [CNT_W-1:0]  r_dwell;
  logic              r_loop;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic [CNT_W-1:0]  r_pass, w_pass_n;
  logic              r_done, w_done_n;
  logic              w_load, w_adv;

  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W:0]   w_sum;
  logic              w_seq_end;
  logic              w_end;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_restart;
  logic [ADDR_W-1:0] w_start_addr;

  assign w_step = (r_stride == '0) ? ONE_A : r_stride;
  assign w_sum  = {1'b0, r_addr} + {1'b0, w_step};
  // Sum is one bit wider, so a carry also shows up as sum > last
  assign w_seq_end = (r_addr == r_last) || w_sum[ADDR_W] ||
                     (w_sum > {1'b0, r_last}) || (r_first > r_last);

`ifdef SEL_SEQ_LFSR_EN
  logic              r_rand;
  logic              w_fb;
  logic [ADDR_W-1:0] w_lfsr;
  logic [ADDR_W-1:0] w_seed_sh;
  logic [ADDR_W-1:0] w_seed_in;

  assign w_fb = r_addr[7] ^ r_addr[5] ^ r_addr[4] ^ r_addr[3];

  always_comb begin
    w_lfsr = '0;
    w_lfsr[7:0] = {r_addr[6:0], w_fb};
    w_seed_sh = '0;
    w_seed_sh[7:0] = (r_first[7:0] == 8'd0) ? 8'd1 : r_first[7:0];
    w_seed_in = '0;
    w_seed_in[7:0] = (cfg_first[7:0] == 8'd0) ? 8'd1 : cfg_first[7:0];
  end

  assign w_end        = r_rand ? (w_lfsr == w_seed_sh) : w_seq_end;
  assign w_next       = r_rand ? w_lfsr : w_sum[ADDR_W-1:0];
  assign w_restart    = r_rand ? w_seed_sh : r_first;
  assign w_start_addr = cfg_rand ? w_seed_in : cfg_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rand <= 1'b0;
    else if (w_load) r_rand <= cfg_rand;
  end
`else
  assign w_end        = w_seq_end;
  assign w_next       = w_sum[ADDR_W-1:0];
  assign w_restart    = r_first;
  assign w_start_addr = cfg_first;
`endif

  always_comb begin
    w_state_n = r_state;
    w_addr_n  = r_addr;
    w_cnt_n   = r_cnt;
    w_pass_n  = r_pass;
    w_done_n  = 1'b0;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_load    = 1'b1;
          w_addr_n  = w_start_addr;
          w_pass_n  = '0;
          w_state_n = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (stop) begin
          w_state_n = S_IDLE;
        end else if (addr_ready) begin
          if (r_dwell == '0) begin
            w_adv = 1'b1;
          end else begin
            w_cnt_n   = r_dwell - ONE_C;
            w_state_n = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (stop) begin
          w_state_n = S_IDLE;
        end else if (r_cnt == '0) begin
          w_adv = 1'b1;
        end else begin
          w_cnt_n = r_cnt - ONE_C;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_adv) begin
      w_state_n = S_PRESENT;
      if (w_end) begin
        w_pass_n = r_pass + ONE_C;
        if (r_loop) begin
          w_addr_n = w_restart;
        end else begin
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end
      end else begin
        w_addr_n = w_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_pass   <= '0;
      r_done   <= 1'b0;
      r_first  <= '0;
      r_last   <= '0;
      r_stride <= '0;
      r_dwell  <= '0;
      r_loop   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_addr  <= w_addr_n;
      r_cnt   <= w_cnt_n;
      r_pass  <= w_pass_n;
      r_done  <= w_done_n;
      if (w_load) begin
        r_first  <= cfg_first;
        r_last   <= cfg_last;
        r_stride <= cfg_stride;
        r_dwell  <= cfg_dwell;
        r_loop   <= cfg_loop;
      end
    end
  end

  assign addr_out   = r_addr;
  assign addr_valid = (r_state == S_PRESENT);
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign pass_cnt   = r_pass;

endmodule

// File: tb/tb_selector_addr_seq.sv
// Scoreboard bench for selector_addr_seq: expected addresses queued at start,
// monitor pops and checks on each handshake, plus dwell gap / done checks.
module tb_selector_addr_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  cfg_first = '0;
  logic [7:0]  cfg_last = '0;
  logic [7:0]  cfg_stride = '0;
  logic [15:0] cfg_dwell = '0;
  logic        cfg_loop = 1'b0;
  logic        cfg_rand = 1'b0;
  logic [7:0]  addr_out;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] pass_cnt;

  selector_addr_seq #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .cfg_first(cfg_first),
    .cfg_last(cfg_last),
    .cfg_stride(cfg_stride),
    .cfg_dwell(cfg_dwell),
    .cfg_loop(cfg_loop),
`ifdef SEL_SEQ_LFSR_EN
    .cfg_rand(cfg_rand),
`endif
    .addr_out(addr_out),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .busy(busy),
    .done(done),
    .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int exp_dwell = 0;
  int exp_pass = 1;
  int n_done = 0;
  int n_acc = 0;
  int rdy_mode = 0;
  bit lfsr_mode = 1'b0;
  int lcount = 0;
  bit seen[256];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // ready driver: 0 = always ready, 1 = random, 2 = never ready
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: addr_ready = 1'b1;
      1: addr_ready = ($urandom_range(0, 3) != 0);
      default: addr_ready = 1'b0;
    endcase
  end

  // monitor
  bit       armed = 1'b0;
  int       gap = 0;
  bit       prev_hold = 1'b0;
  logic [7:0] prev_addr = '0;
  int       last_acc = 0;
  bit       acc;

  always @(negedge clk) begin
    if (!rst_n) begin
      armed = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("hold_addr", addr_out, prev_addr);
      if (done) begin
        n_done++;
        if (armed) chk("gap_end", gap, exp_dwell);
        if (lfsr_mode) chk("lfsr_len", lcount, 255);
        else chk("q_empty", exp_q.size(), 0);
        chk("pass_cnt", pass_cnt, exp_pass);
        chk("done_busy", busy, 0);
        chk("idle_addr", addr_out, last_acc);
        armed = 1'b0;
      end
      if (addr_valid && armed) begin
        chk("gap", gap, exp_dwell);
        armed = 1'b0;
      end
      if (busy && !addr_valid) gap++;
      acc = addr_valid && addr_ready && !stop;
      if (acc) begin
        n_acc++;
        if (lfsr_mode) begin
          chk("lfsr_new", (addr_out != 0) && !seen[addr_out], 1);
          seen[addr_out] = 1'b1;
          lcount++;
        end else if (exp_q.size() == 0) begin
          chk("extra_addr", addr_out, 32'hFFFF_FFFF);
        end else begin
          chk("addr", addr_out, exp_q.pop_front());
        end
        last_acc = addr_out;
        armed = 1'b1;
        gap = 0;
      end
      if (!busy) armed = 1'b0;
      prev_hold = addr_valid && !acc;
      prev_addr = addr_out;
    end
  end

  task automatic build(input int f, input int l, input int s);
    int st = (s == 0) ? 1 : s;
    int a = f;
    forever begin
      exp_q.push_back(a);
      if (f > l || a == l || a + st > l) break;
      a += st;
    end
  endtask

  task automatic start_scan(input int f, input int l, input int s,
                            input int d, input bit lp, input bit poke);
    @(posedge clk); #1;
    cfg_first = f[7:0];
    cfg_last = l[7:0];
    cfg_stride = s[7:0];
    cfg_dwell = d[15:0];
    cfg_loop = lp;
    exp_dwell = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = poke;
    cfg_first = 8'($urandom);
    cfg_last = 8'($urandom);
    cfg_stride = 8'($urandom);
    cfg_dwell = 16'($urandom_range(0, 9));
    cfg_loop = ~lp;
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_done;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_done != d0) break;
    end
    chk("done_seen", n_done != d0, 1);
  endtask

  task automatic run_pass(input int f, input int l, input int s,
                          input int d, input bit poke);
    exp_q.delete();
    build(f, l, s);
    exp_pass = 1;
    start_scan(f, l, s, d, 1'b0, poke);
    wait_done(5000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", addr_out, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    rdy_mode = 0;
    run_pass(1, 1, 1, 0, 1'b0);
    run_pass(0, 10, 3, 0, 1'b1);
    run_pass(250, 255, 4, 0, 1'b0);
    run_pass(9, 3, 2, 1, 1'b0);
    run_pass(4, 8, 0, 0, 1'b0);

    rdy_mode = 2;
    exp_q.delete();
    build(5, 7, 1);
    exp_pass = 1;
    start_scan(5, 7, 1, 3, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    rdy_mode = 0;
    wait_done(200);

    // start and stop together in IDLE: stop wins
    @(posedge clk); #1;
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    chk("startstop_busy", busy, 0);

    // loop scan aborted by stop after 7 accepts
    begin
      int d0;
      exp_q.delete();
      build(0, 2, 1);
      build(0, 2, 1);
      exp_q.push_back(0);
      d0 = n_done;
      n_acc = 0;
      start_scan(0, 2, 1, 0, 1'b1, 1'b0);
      for (int i = 0; i < 100; i++) begin
        if (n_acc >= 7) break;
        @(posedge clk); #1;
      end
      chk("acc7", n_acc, 7);
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      @(negedge clk);
      chk("stop_busy", busy, 0);
      chk("stop_valid", addr_valid, 0);
      chk("stop_pass", pass_cnt, 2);
      chk("stop_q", exp_q.size(), 0);
      chk("stop_nodone", n_done - d0, 0);
    end

    rdy_mode = 1;
    for (int k = 0; k < 10; k++) begin
      int f, l, s;
      f = $urandom_range(0, 255);
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                      : f + $urandom_range(0, 40);
      if (l > 255) l = 255;
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                      : $urandom_range(0, 5);
      run_pass(f, l, s, $urandom_range(0, 3), 1'b0);
    end

    // async reset mid-scan
    rdy_mode = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) build(0, 2, 1);
    start_scan(0, 2, 1, 0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", addr_out, 0);
    chk("arst_valid", addr_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();

`ifdef SEL_SEQ_LFSR_EN
    lfsr_mode = 1'b1;
    lcount = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    exp_pass = 1;
    cfg_rand = 1'b1;
    start_scan(1, 0, 0, 0, 1'b0, 1'b0);
    cfg_rand = 1'b0;
    wait_done(1000);
    lfsr_mode = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
